icache_nb_ctrl: RTL and testbench

ICACHE_NB_CTRL -- requirements
Module: icache_nb_ctrl

---
 rtl/icache_nb_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_icache_nb_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/icache_nb_ctrl.sv
// rtl/icache_nb_ctrl.sv - non-blocking instruction cache controller
// Multi-port hit/bypass path plus MSHR table that issues, tracks and retires memory fills.
module icache_nb_ctrl #(
  parameter int NUM_PORTS  = 2,
  parameter int MSHR_DEPTH = 4,
  parameter int SET_BITS   = 5,
  localparam int TAG_BITS  = 61 - SET_BITS,
  localparam int CNT_W     = $clog2(MSHR_DEPTH) + 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           proc2Icache_valid,
  input  logic [NUM_PORTS-1:0][63:0]     proc2Icache_addr,
  input  logic [NUM_PORTS-1:0]           cachemem_valid,
  input  logic [NUM_PORTS-1:0][63:0]     cachemem_data,
  input  logic [3:0]                     Imem2proc_response,
  input  logic [3:0]                     Imem2proc_tag,
  input  logic [63:0]                    Imem2proc_data,
  output logic [1:0]                     proc2Imem_command,
  output logic [63:0]                    proc2Imem_addr,
  output logic [NUM_PORTS-1:0]           Icache_valid_out,
  output logic [NUM_PORTS-1:0][63:0]     Icache_data_out,
  output logic [NUM_PORTS-1:0]           miss_stall,
  output logic                           data_write_enable,
  output logic [SET_BITS-1:0]            wr_index,
  output logic [TAG_BITS-1:0]            wr_tag,
  output logic [63:0]                    wr_data,
  output logic [CNT_W-1:0]               mshr_count
);

  localparam int IDX_W = $clog2(MSHR_DEPTH);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_PENDING = 2'd1,
    ST_WAIT    = 2'd2
  } mshr_state_e;

  mshr_state_e     state_q [MSHR_DEPTH];
  mshr_state_e     state_d [MSHR_DEPTH];
  logic [60:0]     blk_q   [MSHR_DEPTH];
  logic [60:0]     blk_d   [MSHR_DEPTH];
  logic [3:0]      tag_q   [MSHR_DEPTH];
  logic [3:0]      tag_d   [MSHR_DEPTH];

  logic            cmp_hit;
  logic [IDX_W-1:0] cmp_idx;
  logic [60:0]     cmp_blk;
  logic            iss_hit;
  logic [IDX_W-1:0] iss_idx;
  logic [MSHR_DEPTH-1:0] alloc_en;
  logic [60:0]     alloc_blk [MSHR_DEPTH];
  logic            unused_addr_lsbs;

  // Descending scans so the lowest matching index wins.
  always_comb begin : completion_lookup
    cmp_hit = 1'b0;
    cmp_idx = '0;
    for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
      if (Imem2proc_tag != 4'd0 && state_q[i] == ST_WAIT && tag_q[i] == Imem2proc_tag) begin
        cmp_hit = 1'b1;
        cmp_idx = IDX_W'(i);
      end
    end
  end

  assign cmp_blk = blk_q[cmp_idx];

  always_comb begin : issue_select
    iss_hit = 1'b0;
    iss_idx = '0;
    for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == ST_PENDING) begin
        iss_hit = 1'b1;
        iss_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin : bus_outputs
    proc2Imem_command = BUS_NONE;
    proc2Imem_addr    = 64'd0;
    if (iss_hit) begin
      proc2Imem_command = BUS_LOAD;
      proc2Imem_addr    = {blk_q[iss_idx], 3'b000};
    end
  end

  always_comb begin : fill_outputs
    data_write_enable = cmp_hit;
    wr_index          = '0;
    wr_tag            = '0;
    wr_data           = Imem2proc_data;
    if (cmp_hit) begin
      wr_index = cmp_blk[SET_BITS-1:0];
      wr_tag   = cmp_blk[60:SET_BITS];
    end
  end

  // Ports are walked in priority order; each new block claims the next free entry.
  always_comb begin : port_logic
    logic [MSHR_DEPTH-1:0] taken;
    logic [NUM_PORTS-1:0]  alloc_v;
    logic [60:0]           port_blk [NUM_PORTS];
    logic                  miss;
    logic                  merged;
    logic                  found;
    logic [IDX_W-1:0]      slot;
    taken            = '0;
    alloc_v          = '0;
    miss             = 1'b0;
    merged           = 1'b0;
    found            = 1'b0;
    slot             = '0;
    Icache_valid_out = '0;
    Icache_data_out  = '0;
    miss_stall       = '0;
    alloc_en         = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) alloc_blk[i] = '0;
    for (int p = 0; p < NUM_PORTS; p++) port_blk[p] = proc2Icache_addr[p][63:3];

    for (int p = 0; p < NUM_PORTS; p++) begin
      miss = proc2Icache_valid[p] && !cachemem_valid[p];
      if (proc2Icache_valid[p] && cachemem_valid[p]) begin
        Icache_valid_out[p] = 1'b1;
        Icache_data_out[p]  = cachemem_data[p];
      end else if (miss && cmp_hit && port_blk[p] == cmp_blk) begin
        Icache_valid_out[p] = 1'b1;
        Icache_data_out[p]  = Imem2proc_data;
      end

      merged = cmp_hit && (port_blk[p] == cmp_blk);
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        if (state_q[i] != ST_INVALID && blk_q[i] == port_blk[p]) merged = 1'b1;
      end
      for (int q = 0; q < p; q++) begin
        if (alloc_v[q] && port_blk[q] == port_blk[p]) merged = 1'b1;
      end

      found = 1'b0;
      slot  = '0;
      for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
        if (state_q[i] == ST_INVALID && !taken[i]) begin
          found = 1'b1;
          slot  = IDX_W'(i);
        end
      end

      if (miss && !merged) begin
        if (found) begin
          taken[slot]     = 1'b1;
          alloc_v[p]      = 1'b1;
          alloc_en[slot]  = 1'b1;
          alloc_blk[slot] = port_blk[p];
        end else begin
          miss_stall[p] = 1'b1;
        end
      end
    end
  end

  // Retire, accept and allocate touch disjoint entries (WAIT, PENDING, INVALID).
  always_comb begin : mshr_next
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      state_d[i] = state_q[i];
      blk_d[i]   = blk_q[i];
      tag_d[i]   = tag_q[i];
    end
    if (cmp_hit) state_d[cmp_idx] = ST_INVALID;
    if (iss_hit && Imem2proc_response != 4'd0) begin
      state_d[iss_idx] = ST_WAIT;
      tag_d[iss_idx]   = Imem2proc_response;
    end
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (alloc_en[i]) begin
        state_d[i] = ST_PENDING;
        blk_d[i]   = alloc_blk[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        state_q[i] <= ST_INVALID;
        blk_q[i]   <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        state_q[i] <= state_d[i];
        blk_q[i]   <= blk_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  always_comb begin : occupancy
    mshr_count = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (state_q[i] != ST_INVALID) mshr_count = mshr_count + CNT_W'(1);
    end
  end

  // Byte offset within a block never affects lookup.
  always_comb begin : addr_lsbs
    unused_addr_lsbs = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      unused_addr_lsbs = unused_addr_lsbs ^ (^proc2Icache_addr[p][2:0]);
    end
  end

endmodule

// File: tb/tb_icache_nb_ctrl.sv
// tb/tb_icache_nb_ctrl.sv - directed self-checking bench for icache_nb_ctrl
module tb_icache_nb_ctrl;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic              clock;
  logic              reset;
  logic [1:0]        p_valid;
  logic [1:0][63:0]  p_addr;
  logic [1:0]        c_valid;
  logic [1:0][63:0]  c_data;
  logic [3:0]        resp;
  logic [3:0]        mtag;
  logic [63:0]       mdata;
  logic [1:0]        cmd;
  logic [63:0]       maddr;
  logic [1:0]        vout;
  logic [1:0][63:0]  dout;
  logic [1:0]        stall;
  logic              dwe;
  logic [4:0]        widx;
  logic [55:0]       wtag;
  logic [63:0]       wdata;
  logic [2:0]        count;

  int checks = 0;
  int failures = 0;

  icache_nb_ctrl dut (
    .clock(clock), .reset(reset),
    .proc2Icache_valid(p_valid), .proc2Icache_addr(p_addr),
    .cachemem_valid(c_valid), .cachemem_data(c_data),
    .Imem2proc_response(resp), .Imem2proc_tag(mtag), .Imem2proc_data(mdata),
    .proc2Imem_command(cmd), .proc2Imem_addr(maddr),
    .Icache_valid_out(vout), .Icache_data_out(dout), .miss_stall(stall),
    .data_write_enable(dwe), .wr_index(widx), .wr_tag(wtag), .wr_data(wdata),
    .mshr_count(count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic idle();
    p_valid = '0; p_addr = '0; c_valid = '0; c_data = '0;
    resp = '0; mtag = '0; mdata = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    cyc(); cyc();
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (cmd !== BUS_NONE) begin failures++; $display("FAIL reset_cmd got=%0d exp=%0d", cmd, BUS_NONE); end
    checks++; if (dwe !== 1'b0) begin failures++; $display("FAIL reset_dwe got=%b exp=0", dwe); end
    checks++; if (stall !== 2'b00) begin failures++; $display("FAIL reset_stall got=%b exp=00", stall); end
    reset = 1'b0;
  endtask

  task automatic test_hit();
    cyc(); idle();
    p_valid = 2'b11; p_addr[0] = 64'h9100; p_addr[1] = 64'h9000;
    c_valid = 2'b11; c_data[0] = 64'h66; c_data[1] = 64'h55;
    #1;
    checks++; if (vout !== 2'b11) begin failures++; $display("FAIL hit_valid got=%b exp=11", vout); end
    checks++; if (dout[0] !== 64'h66) begin failures++; $display("FAIL hit_data0 got=%h exp=66", dout[0]); end
    checks++; if (dout[1] !== 64'h55) begin failures++; $display("FAIL hit_data1 got=%h exp=55", dout[1]); end
    cyc(); idle(); #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL hit_count got=%0d exp=0", count); end
  endtask

  task automatic test_basic_miss();
    cyc(); idle();
    p_valid = 2'b01; p_addr[0] = 64'h1000;
    #1;
    checks++; if (vout !== 2'b00) begin failures++; $display("FAIL basic_miss_valid got=%b exp=00", vout); end
    checks++; if (cmd !== BUS_NONE) begin failures++; $display("FAIL basic_pre_cmd got=%0d exp=%0d", cmd, BUS_NONE); end
    cyc(); resp = 4'd3; #1;
    checks++; if (cmd !== BUS_LOAD || maddr !== 64'h1000) begin failures++; $display("FAIL basic_issue got=%0d/%h exp=%0d/1000", cmd, maddr, BUS_LOAD); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
    cyc(); resp = 4'd0; mtag = 4'd3; mdata = 64'hAB; #1;
    checks++; if (cmd !== BUS_NONE) begin failures++; $display("FAIL basic_wait_cmd got=%0d exp=%0d", cmd, BUS_NONE); end
    checks++; if (dwe !== 1'b1 || widx !== 5'd0 || wtag !== 56'h10) begin failures++; $display("FAIL basic_fill got=%b/%h/%h exp=1/0/10", dwe, widx, wtag); end
    checks++; if (wdata !== 64'hAB) begin failures++; $display("FAIL basic_wdata got=%h exp=ab", wdata); end
    checks++; if (vout[0] !== 1'b1 || dout[0] !== 64'hAB) begin failures++; $display("FAIL basic_bypass got=%b/%h exp=1/ab", vout[0], dout[0]); end
    cyc(); idle(); #1;
    checks++; if (count !== 3'd0 || dwe !== 1'b0) begin failures++; $display("FAIL basic_retire got=%0d/%b exp=0/0", count, dwe); end
  endtask

  task automatic test_merge();
    cyc(); idle();
    p_valid = 2'b11; p_addr[0] = 64'h2008; p_addr[1] = 64'h2008;
    #1;
    checks++; if (stall !== 2'b00) begin failures++; $display("FAIL merge_stall got=%b exp=00", stall); end
    cyc(); idle(); resp = 4'd4; #1;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL merge_count got=%0d exp=1", count); end
    checks++; if (cmd !== BUS_LOAD || maddr !== 64'h2008) begin failures++; $display("FAIL merge_issue got=%0d/%h exp=%0d/2008", cmd, maddr, BUS_LOAD); end
    cyc(); resp = 4'd0; mtag = 4'd4; #1;
    checks++; if (cmd !== BUS_NONE) begin failures++; $display("FAIL merge_single_load got=%0d exp=%0d", cmd, BUS_NONE); end
    checks++; if (dwe !== 1'b1 || widx !== 5'd1 || wtag !== 56'h20) begin failures++; $display("FAIL merge_fill got=%b/%h/%h exp=1/1/20", dwe, widx, wtag); end
    cyc(); idle(); #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL merge_retire got=%0d exp=0", count); end
  endtask

  task automatic test_retry();
    logic [3:0] rseq [4];
    rseq[0] = 4'd0; rseq[1] = 4'd0; rseq[2] = 4'd0; rseq[3] = 4'd5;
    cyc(); idle();
    p_valid = 2'b01; p_addr[0] = 64'h3000;
    for (int k = 0; k < 4; k++) begin
      cyc(); idle(); resp = rseq[k]; #1;
      checks++; if (cmd !== BUS_LOAD || maddr !== 64'h3000) begin failures++; $display("FAIL retry_hold_%0d got=%0d/%h exp=%0d/3000", k, cmd, maddr, BUS_LOAD); end
    end
    cyc(); idle(); mtag = 4'd5; #1;
    checks++; if (cmd !== BUS_NONE || count !== 3'd1) begin failures++; $display("FAIL retry_after got=%0d/%0d exp=%0d/1", cmd, count, BUS_NONE); end
    checks++; if (dwe !== 1'b1 || widx !== 5'd0 || wtag !== 56'h30) begin failures++; $display("FAIL retry_fill got=%b/%h/%h exp=1/0/30", dwe, widx, wtag); end
    cyc(); idle(); #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL retry_retire got=%0d exp=0", count); end
  endtask

  task automatic test_out_of_order();
    cyc(); idle();
    p_valid = 2'b11; p_addr[0] = 64'h6018; p_addr[1] = 64'h7020;
    cyc(); idle(); resp = 4'd1; mtag = 4'd9; #1;
    checks++; if (dwe !== 1'b0) begin failures++; $display("FAIL ooo_stray_tag got=%b exp=0", dwe); end
    checks++; if (maddr !== 64'h6018) begin failures++; $display("FAIL ooo_issue0 got=%h exp=6018", maddr); end
    cyc(); idle(); resp = 4'd2; p_valid = 2'b01; p_addr[0] = 64'h8000; #1;
    checks++; if (maddr !== 64'h7020) begin failures++; $display("FAIL ooo_issue1 got=%h exp=7020", maddr); end
    cyc(); idle(); resp = 4'd6; mtag = 4'd2; mdata = 64'h77;
    p_valid = 2'b10; p_addr[1] = 64'h7020; #1;
    checks++; if (cmd !== BUS_LOAD || maddr !== 64'h8000) begin failures++; $display("FAIL ooo_accept_with_fill got=%0d/%h exp=%0d/8000", cmd, maddr, BUS_LOAD); end
    checks++; if (dwe !== 1'b1 || widx !== 5'd4 || wtag !== 56'h70) begin failures++; $display("FAIL ooo_fill_tag2 got=%b/%h/%h exp=1/4/70", dwe, widx, wtag); end
    checks++; if (vout[1] !== 1'b1 || dout[1] !== 64'h77) begin failures++; $display("FAIL ooo_bypass1 got=%b/%h exp=1/77", vout[1], dout[1]); end
    cyc(); idle(); mtag = 4'd1; #1;
    checks++; if (count !== 3'd2 || cmd !== BUS_NONE) begin failures++; $display("FAIL ooo_mid_state got=%0d/%0d exp=2/%0d", count, cmd, BUS_NONE); end
    checks++; if (dwe !== 1'b1 || widx !== 5'd3 || wtag !== 56'h60) begin failures++; $display("FAIL ooo_fill_tag1 got=%b/%h/%h exp=1/3/60", dwe, widx, wtag); end
    cyc(); idle(); mtag = 4'd6; #1;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL ooo_count1 got=%0d exp=1", count); end
    checks++; if (dwe !== 1'b1 || widx !== 5'd0 || wtag !== 56'h80) begin failures++; $display("FAIL ooo_fill_tag6 got=%b/%h/%h exp=1/0/80", dwe, widx, wtag); end
    cyc(); idle(); #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL ooo_retire got=%0d exp=0", count); end
  endtask

  task automatic test_full();
    cyc(); idle();
    p_valid = 2'b11; p_addr[0] = 64'h4000; p_addr[1] = 64'h4008;
    cyc(); resp = 4'd1; p_addr[0] = 64'h4010; p_addr[1] = 64'h4018;
    cyc(); idle(); resp = 4'd2; #1;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    cyc(); resp = 4'd3;
    cyc(); resp = 4'd4;
    cyc(); idle(); p_valid = 2'b01; p_addr[0] = 64'h5000; #1;
    checks++; if (cmd !== BUS_NONE) begin failures++; $display("FAIL full_all_wait got=%0d exp=%0d", cmd, BUS_NONE); end
    checks++; if (stall !== 2'b01) begin failures++; $display("FAIL full_stall got=%b exp=01", stall); end
    cyc(); mtag = 4'd2; #1;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count_held got=%0d exp=4", count); end
    checks++; if (stall !== 2'b01) begin failures++; $display("FAIL full_stall_on_free got=%b exp=01", stall); end
    checks++; if (dwe !== 1'b1 || widx !== 5'd1 || wtag !== 56'h40) begin failures++; $display("FAIL full_fill got=%b/%h/%h exp=1/1/40", dwe, widx, wtag); end
    cyc(); mtag = 4'd0; #1;
    checks++; if (stall !== 2'b00 || count !== 3'd3) begin failures++; $display("FAIL full_retry got=%b/%0d exp=00/3", stall, count); end
    cyc(); idle(); #1;
    checks++; if (count !== 3'd4 || cmd !== BUS_LOAD || maddr !== 64'h5000) begin failures++; $display("FAIL full_realloc got=%0d/%0d/%h exp=4/%0d/5000", count, cmd, maddr, BUS_LOAD); end
  endtask

  task automatic test_reset_discard();
    cyc(); idle(); reset = 1'b1;
    cyc(); reset = 1'b0; mtag = 4'd1; mdata = 64'hDEAD; #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL discard_count got=%0d exp=0", count); end
    checks++; if (dwe !== 1'b0) begin failures++; $display("FAIL discard_dwe got=%b exp=0", dwe); end
    checks++; if (cmd !== BUS_NONE) begin failures++; $display("FAIL discard_cmd got=%0d exp=%0d", cmd, BUS_NONE); end
    cyc(); idle(); #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL discard_count_after got=%0d exp=0", count); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_hit();
    test_basic_miss();
    test_merge();
    test_retry();
    test_out_of_order();
    test_full();
    test_reset_discard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
